psram_async_arbiter: RTL
========================

Name: psram_async_arbiter

Overview:
- Sequences asynchronous-mode read and write cycles on the on-board cellular RAM (PSRAM).
- Arbitrates the RAM between two requesters: port A (video scan-out fetch, read-only, high priority) and port B (host/pixel writer, read/write).
- Sits between the VGA pipeline and the RAM pin pads. Tristate resolution of the data bus is done at the top level.

Parameters:
- ADDR_W, 23, word address width (RAM bus bits 23:1).
- RD_CYCLES, 4, clk cycles CS/OE stay asserted per read (4 × 20 ns = 80 ns ≥ 70 ns tAA at 50 MHz); minimum 2.
- WR_CYCLES, 4, clk cycles CS/WE stay asserted per write; minimum 2.
- TURN_CYCLES, 1, idle cycles after every access (bus release, tCPH); minimum 1.
- A_MAX_RUN, 8, consecutive A grants allowed while B is pending before B is forced in.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A read request; held until a_ack
- a_addr  in  ADDR_W  port A word address
- a_ack  out  1  one-cycle pulse: A request accepted, address latched
- a_rvalid  out  1  one-cycle pulse: a_rdata valid
- a_rdata  out  16  port A read data
- b_req  in  1  port B request; held until b_ack
- b_we  in  1  1 = write, 0 = read
- b_be  in  2  byte enables {upper, lower}, active-high; writes only
- b_addr  in  ADDR_W  port B word address
- b_wdata  in  16  port B write data
- b_ack  out  1  one-cycle accept pulse
- b_rvalid  out  1  one-cycle read-data-valid pulse
- b_rdata  out  16  port B read data
- MemAdr  out  ADDR_W  RAM address
- mem_dq_o  out  16  write data to pads
- mem_dq_oe  out  1  pad output enable
- mem_dq_i  in  16  read data from pads
- MemOE  out  1  active-low output enable
- MemWR  out  1  active-low write enable
- RamCS  out  1  active-low chip select
- RamLB  out  1  active-low lower byte
- RamUB  out  1  active-low upper byte
- RamAdv  out  1  tied 0 (async mode)
- RamClk  out  1  tied 0
- RamCRE  out  1  tied 0

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0 and after release:
  - RamCS=MemOE=MemWR=RamLB=RamUB=1, mem_dq_oe=0.
  - MemAdr=0, mem_dq_o=0.
  - All ack/rvalid outputs=0, a_rdata=b_rdata=0.
  - State=IDLE, run counter=0.
- Reset mid-access: strobes deassert immediately. The in-flight transaction is dropped with no rvalid. Requesters must re-issue.
- All RAM-side outputs are registered, so no combinational glitches reach the pins.
- FSM states: IDLE, RD, WR, TURN.
- IDLE, arbitration decided on the sampling edge:
  - B wins if b_req and (!a_req or run==A_MAX_RUN); otherwise A wins if a_req.
  - A win: run increments (saturating) if b_req, else run clears.
  - B win: run clears.
  - Winner address, we, be and wdata are latched into MemAdr/mem_dq_o.
  - The winner's ack pulses in the first cycle of the next state.
- RD, for RD_CYCLES cycles:
  - RamCS=0, MemOE=0, MemWR=1.
  - RamLB=RamUB=0 (both bytes read regardless of b_be).
  - mem_dq_i is captured on the edge ending the last RD cycle.
  - Go to TURN; the owner's rvalid pulses in the first TURN cycle with rdata.
- WR, for WR_CYCLES cycles:
  - RamCS=0, MemWR=0, MemOE=1, mem_dq_oe=1.
  - RamLB=!be[0], RamUB=!be[1].
  - Go to TURN.
- TURN, for TURN_CYCLES cycles:
  - RamCS=MemOE=MemWR=LB=UB=1.
  - mem_dq_oe stays 1 through the first TURN cycle after a write (data hold), then 0.
  - Go to IDLE.
- Latency:
  - req (held in IDLE) to ack: 1 cycle.
  - Read: req to rvalid = RD_CYCLES+1.
  - Access period = 1+max(RD,WR)_CYCLES+TURN_CYCLES (6 cycles default).
- rdata holds its value until the next read for that port.
- A write with b_be=00 still runs the WR timing; no bytes are written.
- Both requests arriving on the same edge: A wins unless run==A_MAX_RUN.
- A request dropped before ack: ignored if it is low at the IDLE sample.
- MemOE and MemWR are never both 0. mem_dq_oe is never 1 while MemOE=0.

Decomposition:
- Package psram_pkg holds:
  - the state enum {IDLE, RD, WR, TURN};
  - owner encoding (OWN_A, OWN_B);
  - default timing constants.
- One sub-module, mem_cycle_timer: a loadable down-counter with a done flag, reused for the RD, WR and TURN durations.

Test Plan:
- Reset: pulse rst_n low mid-RD -> RamCS/MemOE go to 1 asynchronously; no a_rvalid; all outputs at reset values.
- Single A read: a_addr=0x000123, RAM model returns 0xBEEF -> a_ack at +1; MemOE=0 for 4 cycles; a_rvalid at +5 with a_rdata=0xBEEF.
- B byte write: b_we=1, b_be=10, b_wdata=0x5AA5 -> MemWR=0 for 4 cycles, RamUB=0, RamLB=1, mem_dq_oe high 5 cycles; model shows only the upper byte updated.
- Simultaneous a_req and b_req in IDLE, both held continuously -> 8 A grants, then 1 B grant, repeating; each grant is spaced exactly 6 cycles apart.
- Back-to-back B read after B write to the same address -> b_rvalid returns the written data; mem_dq_oe=0 while MemOE=0 (assertion).
- Request withdrawn: a_req high only during TURN -> no a_ack; FSM stays IDLE.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and default timing for the asynchronous PSRAM arbiter.
package psram_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned TMR_W           = 8;
  localparam int unsigned RUN_W           = 8;

  localparam int unsigned DEF_ADDR_W      = 23;
  localparam int unsigned DEF_RD_CYCLES   = 4;
  localparam int unsigned DEF_WR_CYCLES   = 4;
  localparam int unsigned DEF_TURN_CYCLES = 1;
  localparam int unsigned DEF_A_MAX_RUN   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_cycle_timer.sv
// Loadable down-counter; done_c is high once the loaded count has run out.
module mem_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/psram_async_arbiter.sv
// Two-port arbiter and async-mode cycle sequencer for the cellular RAM.
// Port A (read-only) has priority; B is forced in after A_MAX_RUN A grants.
module psram_async_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RD_CYCLES   = DEF_RD_CYCLES,
  parameter int unsigned WR_CYCLES   = DEF_WR_CYCLES,
  parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int unsigned A_MAX_RUN   = DEF_A_MAX_RUN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCS,
  output logic              RamLB,
  output logic              RamUB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCRE
);

  state_t              state, nState;
  owner_t              owner, nOwner;
  logic [RUN_W-1:0]    run, nRun;
  logic [1:0]          be, nBe;
  logic [ADDR_W-1:0]   nAdr;
  logic [DATA_W-1:0]   nDqO, nARdata, nBRdata;
  logic                nAAck, nBAck, nARv, nBRv;
  logic                nCs, nOe, nWr, nLb, nUb, nDqOe;
  logic                bWin;
  logic                tmrLoad;
  logic [TMR_W-1:0]    tmrVal;
  logic                tmrDone_c;

  mem_cycle_timer #(.W(TMR_W)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmrLoad),
    .loadVal (tmrVal),
    .done_c  (tmrDone_c)
  );

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    nState  = state;
    nOwner  = owner;
    nRun    = run;
    nBe     = be;
    nAdr    = MemAdr;
    nDqO    = mem_dq_o;
    nARdata = a_rdata;
    nBRdata = b_rdata;
    nAAck   = 1'b0;
    nBAck   = 1'b0;
    nARv    = 1'b0;
    nBRv    = 1'b0;
    nCs     = 1'b1;
    nOe     = 1'b1;
    nWr     = 1'b1;
    nLb     = 1'b1;
    nUb     = 1'b1;
    nDqOe   = 1'b0;
    tmrLoad = 1'b0;
    tmrVal  = '0;
    bWin    = b_req && (!a_req || (run == RUN_W'(A_MAX_RUN)));

    case (state)
      IDLE: begin
        if (bWin) begin
          nOwner  = OWN_B;
          nRun    = '0;
          nAdr    = b_addr;
          nBe     = b_be;
          nDqO    = b_wdata;
          nBAck   = 1'b1;
          tmrLoad = 1'b1;
          if (b_we) begin
            nState = WR;
            tmrVal = TMR_W'(WR_CYCLES - 1);
          end else begin
            nState = RD;
            tmrVal = TMR_W'(RD_CYCLES - 1);
          end
        end else if (a_req) begin
          nOwner  = OWN_A;
          nAdr    = a_addr;
          nBe     = 2'b11;
          nAAck   = 1'b1;
          nState  = RD;
          tmrLoad = 1'b1;
          tmrVal  = TMR_W'(RD_CYCLES - 1);
          if (!b_req) begin
            nRun = '0;
          end else if (run != RUN_W'(A_MAX_RUN)) begin
            nRun = run + RUN_W'(1);
          end
        end
      end
      RD: begin
        if (tmrDone_c) begin
          nState  = TURN;
          tmrLoad = 1'b1;
          tmrVal  = TMR_W'(TURN_CYCLES - 1);
          if (owner == OWN_A) begin
            nARv    = 1'b1;
            nARdata = mem_dq_i;
          end else begin
            nBRv    = 1'b1;
            nBRdata = mem_dq_i;
          end
        end
      end
      WR: begin
        if (tmrDone_c) begin
          nState  = TURN;
          tmrLoad = 1'b1;
          tmrVal  = TMR_W'(TURN_CYCLES - 1);
        end
      end
      TURN: begin
        if (tmrDone_c) begin
          nState = IDLE;
        end
      end
      default: nState = IDLE;
    endcase

    // Pin strobes follow the state being entered, so they are registered.
    case (nState)
      RD: begin
        nCs = 1'b0;
        nOe = 1'b0;
        nLb = 1'b0;
        nUb = 1'b0;
      end
      WR: begin
        nCs   = 1'b0;
        nWr   = 1'b0;
        nDqOe = 1'b1;
        nLb   = !nBe[0];
        nUb   = !nBe[1];
      end
      TURN: begin
        // Hold write data one cycle past WE release.
        nDqOe = (state == WR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_A;
      run       <= '0;
      be        <= '0;
      MemAdr    <= '0;
      mem_dq_o  <= '0;
      mem_dq_oe <= 1'b0;
      MemOE     <= 1'b1;
      MemWR     <= 1'b1;
      RamCS     <= 1'b1;
      RamLB     <= 1'b1;
      RamUB     <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state     <= nState;
      owner     <= nOwner;
      run       <= nRun;
      be        <= nBe;
      MemAdr    <= nAdr;
      mem_dq_o  <= nDqO;
      mem_dq_oe <= nDqOe;
      MemOE     <= nOe;
      MemWR     <= nWr;
      RamCS     <= nCs;
      RamLB     <= nLb;
      RamUB     <= nUb;
      a_ack     <= nAAck;
      b_ack     <= nBAck;
      a_rvalid  <= nARv;
      b_rvalid  <= nBRv;
      a_rdata   <= nARdata;
      b_rdata   <= nBRdata;
    end
  end

  assign RamAdv = 1'b0;
  assign RamClk = 1'b0;
  assign RamCRE = 1'b0;

endmodule
